word_cmd_engine: RTL and testbench

- Consumes 16-bit words delivered by the UART transceiver's receive side and decodes them as host commands: NOP, register WRITE, register READ and ECHO.
- Acts on a small 16-bit register file.
- Queues 16-bit response words in a 4-entry FIFO for the transceiver's send side.
- Sits between the transceiver receive output and its send input, replacing the current loopback wiring in the FPGA top.

---
 rtl/word_cmd_pkg.sv | 26 ++
 rtl/resp_fifo.sv | 44 ++++
 rtl/word_cmd_engine.sv | 126 ++++++++++++
 tb/tb_word_cmd_engine.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/word_cmd_pkg.sv
// Shared types and constants for the UART word command engine.
package word_cmd_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_ECHO  = 2'b11
  } op_t;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_DATA = 1'b1
  } state_t;

  localparam logic [15:0] RESP_ERR = 16'hEEEE;
  localparam logic [7:0]  ACK_TAG  = 8'hA5;
  localparam logic [1:0]  ECHO_TAG = 2'b11;
  localparam logic [1:0]  WR_TAG   = 2'b01;

  // Command addresses are 6 bits, so the register count is capped at 64.
  function automatic logic addr_ok(input logic [5:0] a, input int n);
    return {1'b0, a} < 7'(n);
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// First-word fall-through response FIFO; extra pointer bit separates full from empty.
module resp_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             empty,
  output logic             full,
  output logic [WIDTH-1:0] head,
  output logic             drop
);
  localparam int PW = $clog2(DEPTH) + 1;

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop_ok, push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign head    = mem[rd_ptr[PW-2:0]];
  assign pop_ok  = pop && !empty;
  // A full FIFO still takes the word when the head leaves on the same edge.
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;

  always_ff @(posedge clk) begin
    if (rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[PW-2:0]] <= push_data;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/word_cmd_engine.sv
// Decodes host command words into register file accesses and queues response words.
module word_cmd_engine
  import word_cmd_pkg::*;
#(
  parameter int NUM_REGS     = 16,
  parameter int TIMEOUT_CLKS = 100000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [15:0] cmd_data,
  input  logic        cmd_valid,
  output logic [15:0] resp_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [7:0]  led,
  output logic [7:0]  err_cnt,
  output logic        ovf
);
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  state_t        state, state_nxt;
  logic [15:0]   regs [NUM_REGS];
  logic [5:0]    waddr;
  logic [TW-1:0] tcnt;
  op_t           op;
  logic [5:0]    addr;
  logic          push, wr_en, err_inc, latch;
  logic [15:0]   push_data;
  logic          empty, drop, fifo_full_unused;

  assign op   = op_t'(cmd_data[15:14]);
  assign addr = cmd_data[13:8];

  always_ff @(posedge clk) begin
    if (rstb) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_data = 16'h0000;
    wr_en     = 1'b0;
    err_inc   = 1'b0;
    latch     = 1'b0;
    case (state)
      IDLE: if (cmd_valid) begin
        case (op)
          OP_NOP: ;
          OP_WRITE: begin
            state_nxt = WAIT_DATA;
            latch     = 1'b1;
          end
          OP_READ: begin
            push = 1'b1;
            if (addr_ok(addr, NUM_REGS)) push_data = regs[addr[AW-1:0]];
            else begin
              push_data = RESP_ERR;
              err_inc   = 1'b1;
            end
          end
          OP_ECHO: begin
            push      = 1'b1;
            push_data = {ECHO_TAG, cmd_data[13:0]};
          end
        endcase
      end
      WAIT_DATA: begin
        // A data word on the timeout cycle takes priority over the timeout.
        if (cmd_valid) begin
          state_nxt = IDLE;
          push      = 1'b1;
          if (addr_ok(waddr, NUM_REGS)) begin
            wr_en     = 1'b1;
            push_data = {WR_TAG, waddr, ACK_TAG};
          end else begin
            push_data = RESP_ERR;
            err_inc   = 1'b1;
          end
        end else if (tcnt == TW'(TIMEOUT_CLKS - 1)) begin
          state_nxt = IDLE;
          err_inc   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      waddr   <= '0;
      tcnt    <= '0;
      err_cnt <= '0;
      ovf     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (latch) begin
        waddr <= addr;
        tcnt  <= '0;
      end else if (state == WAIT_DATA && !cmd_valid) begin
        tcnt <= tcnt + TW'(1);
      end
      if (wr_en) regs[waddr[AW-1:0]] <= cmd_data;
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (drop) ovf <= 1'b1;
    end
  end

  assign led        = regs[0][7:0];
  assign resp_valid = !empty;

  resp_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rstb      (rstb),
    .push      (push),
    .push_data (push_data),
    .pop       (resp_ready),
    .empty     (empty),
    .full      (fifo_full_unused),
    .head      (resp_data),
    .drop      (drop)
  );

endmodule

// File: tb/tb_word_cmd_engine.sv
// Self-checking bench for word_cmd_engine with a transaction-level command model.
module tb_word_cmd_engine;
  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rstb = 1'b1;
  logic [15:0] cmd_data = 16'h0;
  logic        cmd_valid = 1'b0;
  logic [15:0] resp_data;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [7:0]  led, err_cnt;
  logic        ovf;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] mregs [16];
  logic        m_pend;
  logic [5:0]  m_addr;
  int          m_err;

  word_cmd_engine #(.NUM_REGS(16), .TIMEOUT_CLKS(TO), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rstb(rstb), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .led(led), .err_cnt(err_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Every word the transceiver would accept on the coming edge.
  always @(negedge clk)
    if (!rstb && resp_valid && resp_ready) got_q.push_back(resp_data);

  task automatic do_reset();
    @(posedge clk); #1 rstb = 1'b1; cmd_valid = 1'b0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstb = 1'b0;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 16; i++) mregs[i] = 16'h0;
    m_pend = 1'b0; m_addr = '0; m_err = 0;
  endtask

  task automatic send(input logic [15:0] w);
    @(posedge clk); #1 cmd_data = w; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
  endtask

  // Command semantics at the transaction level: pending write flag plus address.
  task automatic model_cmd(input logic [15:0] w);
    if (m_pend) begin
      m_pend = 1'b0;
      if (m_addr < 16) begin mregs[m_addr] = w; exp_q.push_back({2'b01, m_addr, 8'hA5}); end
      else begin exp_q.push_back(16'hEEEE); m_err++; end
    end else begin
      case (w[15:14])
        2'd1: begin m_pend = 1'b1; m_addr = w[13:8]; end
        2'd2: if (w[13:8] < 16) exp_q.push_back(mregs[w[13:8]]);
              else begin exp_q.push_back(16'hEEEE); m_err++; end
        2'd3: exp_q.push_back({2'b11, w[13:0]});
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", resp_valid); end
    n_chk++; if (resp_data !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0000", resp_data); end
    n_chk++; if (led !== 8'h0) begin n_fail++; $display("FAIL reset_led got %h exp 00", led); end
    n_chk++; if (err_cnt !== 8'h0 || ovf !== 1'b0) begin n_fail++; $display("FAIL reset_err got %h/%b exp 00/0", err_cnt, ovf); end
  endtask

  task automatic test_write_read();
    do_reset();
    send(16'h4300); send(16'hBEEF); repeat (3) @(posedge clk);
    n_chk++; if (got_q.size() != 1 || got_q[0] !== 16'h43A5) begin n_fail++; $display("FAIL write_ack got n=%0d %h exp 43A5", got_q.size(), got_q.size() ? got_q[0] : 16'hx); end
    got_q.delete();
    send(16'h8300); repeat (3) @(posedge clk);
    n_chk++; if (got_q.size() != 1 || got_q[0] !== 16'hBEEF) begin n_fail++; $display("FAIL read_back got n=%0d %h exp BEEF", got_q.size(), got_q.size() ? got_q[0] : 16'hx); end
  endtask

  task automatic test_led();
    do_reset();
    send(16'h4000); send(16'h1234);
    n_chk++; if (led !== 8'h34) begin n_fail++; $display("FAIL led got %h exp 34", led); end
    repeat (2) @(posedge clk);
    n_chk++; if (got_q.size() != 1 || got_q[0] !== 16'h40A5) begin n_fail++; $display("FAIL led_ack got n=%0d exp 40A5", got_q.size()); end
  endtask

  task automatic test_read_oob();
    do_reset();
    send(16'h9F00); repeat (3) @(posedge clk);
    n_chk++; if (got_q.size() != 1 || got_q[0] !== 16'hEEEE) begin n_fail++; $display("FAIL oob_resp got n=%0d exp EEEE", got_q.size()); end
    n_chk++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL oob_err got %0d exp 1", err_cnt); end
  endtask

  task automatic test_echo_nop();
    do_reset();
    send(16'hC123);
    n_chk++; if (resp_valid !== 1'b1 || resp_data !== 16'hC123) begin n_fail++; $display("FAIL echo_latency got %b/%h exp 1/C123", resp_valid, resp_data); end
    repeat (2) @(posedge clk); got_q.delete();
    send(16'h0000); repeat (4) @(posedge clk);
    n_chk++; if (got_q.size() != 0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL nop_resp got n=%0d exp 0", got_q.size()); end
  endtask

  task automatic test_overflow();
    logic [15:0] w;
    do_reset();
    resp_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin w = 16'hC000 + 16'(i); send(w); end
    n_chk++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", ovf); end
    n_chk++; if (resp_data !== 16'hC001) begin n_fail++; $display("FAIL ovf_head got %h exp C001", resp_data); end
    @(posedge clk); #1 resp_ready = 1'b1;
    repeat (8) @(posedge clk);
    n_chk++; if (got_q.size() != 4) begin n_fail++; $display("FAIL ovf_count got %0d exp 4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      w = 16'hC001 + 16'(i);
      n_chk++; if (got_q[i] !== w) begin n_fail++; $display("FAIL ovf_order[%0d] got %h exp %h", i, got_q[i], w); end
    end
    n_chk++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
  endtask

  task automatic test_timeout();
    do_reset();
    send(16'h4100); repeat (TO + 10) @(posedge clk);
    n_chk++; if (err_cnt !== 8'd1 || got_q.size() != 0) begin n_fail++; $display("FAIL timeout got err=%0d n=%0d exp 1/0", err_cnt, got_q.size()); end
    send(16'h8100); repeat (3) @(posedge clk);
    n_chk++; if (got_q.size() != 1 || got_q[0] !== 16'h0000) begin n_fail++; $display("FAIL timeout_read got n=%0d exp 0000", got_q.size()); end
    // Data on the last allowed cycle is still accepted.
    do_reset();
    send(16'h4200); repeat (TO - 2) @(posedge clk); send(16'h5A5A); repeat (3) @(posedge clk);
    n_chk++; if (got_q.size() != 1 || got_q[0] !== 16'h42A5 || err_cnt !== 8'd0) begin n_fail++; $display("FAIL timeout_edge_in got n=%0d err=%0d exp 42A5/0", got_q.size(), err_cnt); end
    // One cycle later the write has already expired.
    do_reset();
    send(16'h4200); repeat (TO - 1) @(posedge clk); send(16'h0000); repeat (3) @(posedge clk);
    n_chk++; if (got_q.size() != 0 || err_cnt !== 8'd1) begin n_fail++; $display("FAIL timeout_edge_out got n=%0d err=%0d exp 0/1", got_q.size(), err_cnt); end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    send(16'h4500);
    @(posedge clk); #1 rstb = 1'b1; @(posedge clk); #1 rstb = 1'b0;
    send(16'h1111); repeat (3) @(posedge clk);
    n_chk++; if (got_q.size() != 0 || err_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_mid got n=%0d err=%0d exp 0/0", got_q.size(), err_cnt); end
    send(16'h8500); repeat (3) @(posedge clk);
    n_chk++; if (got_q.size() != 1 || got_q[0] !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_read got n=%0d exp 0000", got_q.size()); end
  endtask

  task automatic test_random();
    logic [15:0] w;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      w = 16'($urandom);
      w[13:8] = 6'($urandom_range(0, 19));
      model_cmd(w); send(w);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    if (m_pend) begin model_cmd(16'h7777); send(16'h7777); end
    repeat (5) @(posedge clk);
    n_chk++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_resp[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    n_chk++; if (err_cnt !== 8'((m_err > 255) ? 255 : m_err)) begin n_fail++; $display("FAIL rand_err got %0d exp %0d", err_cnt, m_err); end
    n_chk++; if (led !== mregs[0][7:0]) begin n_fail++; $display("FAIL rand_led got %h exp %h", led, mregs[0][7:0]); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_led();
    test_read_oob();
    test_echo_nop();
    test_overflow();
    test_timeout();
    test_reset_mid_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
